// File: rtl/dmem_slots.sv
// dmem_slots: 32-bit word memory addressed by TLB slot index, zero-filled after reset.
// Byte strobes are honoured only when DMEM_WSTRB_EN is defined; otherwise writes are full-word.
module dmem_slots #(
    parameter  int MEM_SLOTS_COUNT = 32,
    localparam int SW              = $clog2(MEM_SLOTS_COUNT)
) (
    input  logic          _clk,
    input  logic          _reset,
    input  logic          _req_valid,
    output logic          req_ready_,
    input  logic          _we,
    input  logic [SW-1:0] _slot_n,
    input  logic [31:0]   _wdata,
    input  logic [3:0]    _wstrb,
    output logic          resp_valid_,
    input  logic          _resp_ready,
    output logic [31:0]   rdata_,
    output logic          init_done_
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state_reg;
    logic [SW-1:0] cnt_reg;
    logic          resp_valid_reg;
    logic          init_done_reg;

    logic          accept;
    logic          consume;
    logic [3:0]    wstrb_eff;
    logic [3:0]    lane_en;
    logic [SW-1:0] mem_addr;
    logic [31:0]   mem_din;

`ifdef DMEM_WSTRB_EN
    assign wstrb_eff = _wstrb;
`else
    assign wstrb_eff = 4'hF;
    logic unused_wstrb;
    assign unused_wstrb = ^_wstrb;
`endif

    // Single-entry output register: a new request may enter as the old response leaves.
    assign req_ready_  = (state_reg == ST_RUN) && (!resp_valid_reg || _resp_ready);
    assign accept      = _req_valid && req_ready_;
    assign consume     = resp_valid_reg && _resp_ready;
    assign resp_valid_ = resp_valid_reg;
    assign init_done_  = init_done_reg;

    always_ff @(posedge _clk or negedge _reset) begin
        if (!_reset) begin
            state_reg      <= ST_INIT;
            cnt_reg        <= '0;
            resp_valid_reg <= 1'b0;
            init_done_reg  <= 1'b0;
        end else if (state_reg == ST_INIT) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == SW'(MEM_SLOTS_COUNT - 1)) begin
                state_reg     <= ST_RUN;
                init_done_reg <= 1'b1;
            end
        end else begin
            if (accept) begin
                resp_valid_reg <= 1'b1;
            end else if (consume) begin
                resp_valid_reg <= 1'b0;
            end
        end
    end

    // The sweep owns the write port during INIT; afterwards it follows accepted writes.
    assign mem_addr = (state_reg == ST_INIT) ? cnt_reg : _slot_n;
    assign mem_din  = (state_reg == ST_INIT) ? 32'h0 : _wdata;
    assign lane_en  = (state_reg == ST_INIT) ? 4'hF :
                      ((accept && _we) ? wstrb_eff : 4'h0);

    // One byte-wide array per lane: unstrobed lanes echo the old byte read in the same cycle.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem_lane [MEM_SLOTS_COUNT];
            logic [7:0] rd_reg;

            always_ff @(posedge _clk) begin
                if (lane_en[gi]) begin
                    mem_lane[mem_addr] <= mem_din[8*gi +: 8];
                end
            end

            always_ff @(posedge _clk or negedge _reset) begin
                if (!_reset) begin
                    rd_reg <= 8'h0;
                end else if (accept) begin
                    rd_reg <= (_we && wstrb_eff[gi]) ? _wdata[8*gi +: 8] : mem_lane[_slot_n];
                end
            end

            assign rdata_[8*gi +: 8] = rd_reg;
        end
    endgenerate

endmodule
